// File: rtl/panel_loader_pkg.sv
// Shared definitions for the front-panel image loader: FSM states, press phases and defaults.
package panel_loader_pkg;

  localparam int unsigned DefWordW      = 12;
  localparam int unsigned DefAddrW      = 12;
  localparam int unsigned DefHoldCycles = 10;

  typedef enum logic [2:0] {
    StIdle,
    StBasePc,
    StFetch,
    StCapture,
    StDep,
    StEndPc,
    StRun,
    StFinish
  } loader_state_e;

  typedef enum logic [1:0] {
    PhSetup,
    PhAssert,
    PhRelease
  } press_phase_e;

  // Width of the hold down-counter; never zero, even for a one-cycle hold.
  function automatic int unsigned press_cnt_w(int unsigned hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/panel_press_timer.sv
// Paces one panel press: SETUP, ASSERT and RELEASE phases of HOLD_CYCLES each.
module panel_press_timer
  import panel_loader_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  output press_phase_e phase,
  output logic         press_done
);

  localparam int unsigned     CntW   = press_cnt_w(HOLD_CYCLES);
  localparam logic [CntW-1:0] Reload = CntW'(HOLD_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  press_phase_e    phase_q, phase_d;

  // Idle between presses so the next press always opens with a full SETUP.
  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    press_done = 1'b0;
    if (!run) begin
      cnt_d   = Reload;
      phase_d = PhSetup;
    end else if (cnt_q == '0) begin
      cnt_d = Reload;
      case (phase_q)
        PhSetup:  phase_d = PhAssert;
        PhAssert: phase_d = PhRelease;
        default: begin
          phase_d    = PhSetup;
          press_done = 1'b1;
        end
      endcase
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= Reload;
      phase_q <= PhSetup;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/panel_loader.sv
// Loads a memory image through the front-panel switches, then sets the PC and optionally runs.
module panel_loader
  import panel_loader_pkg::*;
#(
  parameter int unsigned WORD_W      = DefWordW,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              run_en,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [WORD_W-1:0] src_data,
  output logic [WORD_W:0]   sw,
  output logic              deposit,
  output logic              load_pc,
  output logic              busy,
  output logic              done
);

  loader_state_e     state_q, state_d;
  logic [WORD_W-1:0] sw_data_q, sw_data_d;
  logic              run_bit_q, run_bit_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic              run_en_q, run_en_d;

  logic         press_run;
  logic         press_done;
  press_phase_e phase;

  assign press_run = (state_q == StBasePc) || (state_q == StDep) || (state_q == StEndPc);

  panel_press_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (press_run),
    .phase     (phase),
    .press_done(press_done)
  );

  // sw data only moves on state entry, never while a strobe could be active.
  always_comb begin
    state_d    = state_q;
    sw_data_d  = sw_data_q;
    run_bit_d  = run_bit_q;
    idx_d      = idx_q;
    count_d    = count_q;
    start_pc_d = start_pc_q;
    run_en_d   = run_en_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StBasePc;
          run_bit_d  = 1'b0;
          sw_data_d  = WORD_W'(base_addr);
          count_d    = word_count;
          start_pc_d = start_pc;
          run_en_d   = run_en;
          idx_d      = '0;
        end
      end
      StBasePc: begin
        if (press_done) begin
          if (count_q != '0) begin
            state_d = StFetch;
          end else begin
            state_d   = StEndPc;
            sw_data_d = WORD_W'(start_pc_q);
          end
        end
      end
      StFetch:   state_d = StCapture;
      StCapture: begin
        sw_data_d = src_data;
        state_d   = StDep;
      end
      StDep: begin
        if (press_done) begin
          idx_d = idx_q + 1'b1;
          if (idx_d == count_q) begin
            state_d   = StEndPc;
            sw_data_d = WORD_W'(start_pc_q);
          end else begin
            state_d = StFetch;
          end
        end
      end
      StEndPc: begin
        if (press_done) begin
          if (run_en_q) begin
            state_d   = StRun;
            run_bit_d = 1'b1;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StRun:    state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sw_data_q  <= '0;
      run_bit_q  <= 1'b0;
      idx_q      <= '0;
      count_q    <= '0;
      start_pc_q <= '0;
      run_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_data_q  <= sw_data_d;
      run_bit_q  <= run_bit_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      start_pc_q <= start_pc_d;
      run_en_q   <= run_en_d;
    end
  end

  assign sw        = {run_bit_q, sw_data_q};
  assign load_pc   = ((state_q == StBasePc) || (state_q == StEndPc)) && (phase == PhAssert);
  assign deposit   = (state_q == StDep) && (phase == PhAssert);
  assign src_rd_en = (state_q == StFetch);
  assign src_addr  = (state_q == StFetch) ? idx_q[ADDR_W-1:0] : '0;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish);

endmodule

// File: doc/panel_loader.md
PANEL_LOADER -- requirements
Module: panel_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 12, meaning panel word width.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning image address width.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 10, meaning clk cycles per panel phase; legal range is 1 or more.
REQ-004 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load sequence.
- base_addr  in  ADDR_W  first panel address to deposit.
- word_count  in  ADDR_W+1  number of words to deposit; 0 is legal.
- start_pc  in  ADDR_W  PC value loaded after the image.
- run_en  in  1  assert run after load when 1.
- src_rd_en  out  1  image memory read strobe.
- src_addr  out  ADDR_W  image memory read address, offset from 0.
- src_data  in  WORD_W  image read data, valid exactly 1 cycle after src_rd_en.
- sw  out  WORD_W+1  panel switches; bit WORD_W is run, lower bits are data.
- deposit  out  1  panel deposit button.
- load_pc  out  1  panel load-PC button.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

Function
REQ-005 Every panel "press" SHALL be 3 phases of HOLD_CYCLES each: SETUP (sw data stable, strobe 0), ASSERT (strobe 1), RELEASE (strobe 0, sw data held).
REQ-006 The FSM states SHALL be IDLE, BASE_PC, FETCH, CAPTURE, DEP, END_PC, RUN, FINISH.
REQ-007 IDLE SHALL transition to BASE_PC when start=1, clearing sw[WORD_W] and latching base_addr, word_count, start_pc and run_en.
REQ-008 BASE_PC SHALL drive sw data = base_addr, zero-extended, and perform one load_pc press.
- It SHALL then go to FETCH if the latched count is nonzero, else to END_PC.
REQ-009 FETCH SHALL last 1 cycle with src_rd_en=1 and src_addr=word index.
REQ-010 CAPTURE SHALL last 1 cycle and register src_data into sw data.
REQ-011 DEP SHALL perform one deposit press and then increment the word index.
- If index = count, the FSM SHALL go to END_PC; otherwise it SHALL go to FETCH.
- Each word therefore costs 2+3*HOLD_CYCLES cycles.
REQ-012 END_PC SHALL perform one load_pc press with sw data = start_pc.
- It SHALL then go to RUN if run_en was latched, else to FINISH.
REQ-013 RUN SHALL set sw[WORD_W]=1 for 1 cycle, then go to FINISH.
- sw[WORD_W] SHALL stay 1 until reset or the next accepted start.
REQ-014 FINISH SHALL pulse done for 1 cycle and return to IDLE.
REQ-015 start while busy SHALL be ignored, with no latch update.
REQ-016 deposit and load_pc SHALL never be high in the same cycle.
REQ-017 A strobe SHALL never rise or fall in the same cycle that sw data changes.
REQ-018 The word index SHALL be ADDR_W+1 bits wide.
- word_count = 2^ADDR_W SHALL deposit the full space with no index wrap.
- Panel address wrap is the CPU's concern.
REQ-019 Total sequence length SHALL be 3H + N(2+3H) + 3H + (run_en?1:0) + 1 cycles after start, where H = HOLD_CYCLES and N = word_count.

Reset
REQ-020 reset SHALL force IDLE and zero all outputs (sw, deposit, load_pc, src_rd_en, src_addr, busy, done) on the next posedge, including mid-press.
REQ-021 The first start after reset SHALL behave identically to the first start from power-up.

Structure
REQ-022 The FSM state enum and default parameter constants SHALL live in the shared CPU definitions package.
REQ-023 The phase timer (HOLD_CYCLES down-counter plus SETUP/ASSERT/RELEASE phase tracking, with a press-complete output) SHALL be one sub-module named panel_press_timer.
- It SHALL be instantiated once and shared by all presses.

Verification
REQ-024 H=2, base=0, count=3, image {0o7200,0o1177,0o7402}, start_pc=0o0200, run_en=1 -> the panel sees, in order:
- load_pc with sw=0;
- deposits of 0o7200, 0o1177, 0o7402;
- load_pc with sw=0o0200;
- sw[12]=1;
- done after exactly 6+3*8+6+1+1=38 cycles.
REQ-025 count=0, start_pc=0o0200, run_en=0 -> two load_pc presses, no deposit, no src_rd_en, done after 13 cycles, sw[12]=0.
REQ-026 reset asserted during the ASSERT phase of the second deposit -> next cycle all outputs 0 and state IDLE; a subsequent start reloads from word 0.
REQ-027 start pulsed again while busy with different base_addr -> ignored; deposited addresses and data match the first request.
REQ-028 H=1, ADDR_W=4, count=16 -> 16 deposits, index reaches 16 without wrap, done asserted once.
REQ-029 All scenarios -> checker confirms deposit and load_pc are never both high, and sw data never changes while a strobe is high or in its edge cycle.
